// File: rtl/motor_pkg.sv
// motor_pkg: shared states and constants for the motor executor
package motor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam int DIR_BIT         = 7;
    localparam int SPEED_W         = 7;
    localparam int PWM_DIV_DEF     = 16;
    localparam int TICK_CYCLES_DEF = 400000;
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: duty compare and H-bridge steering for one motor
module pwm_gen import motor_pkg::*; (
    input  logic               i_en,
    input  logic [SPEED_W-1:0] i_phase,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_dir,
    output logic               o_a,
    output logic               o_b
);
    logic w_act;
    assign w_act = i_en && (i_phase < i_speed);
    assign o_a   = w_act && i_dir;
    assign o_b   = w_act && !i_dir;
endmodule

// File: rtl/motor_exec.sv
// motor_exec: timed dual-motor PWM run controller with IDLE/RUN/HOLD handshake
module motor_exec import motor_pkg::*; #(
    parameter int PWM_DIV     = PWM_DIV_DEF,
    parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       executeStart,
    input  logic [7:0] lmotor,
    input  logic [7:0] rmotor,
    input  logic [7:0] dur,
    output logic       executeComplete,
    output logic       lmotorA,
    output logic       lmotorB,
    output logic       rmotorA,
    output logic       rmotorB
);
    localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t             r_state, w_next;
    logic [7:0]         r_l, r_r, r_dur, r_units;
    logic [TW-1:0]      r_tick;
    logic [DW-1:0]      r_div;
    logic [SPEED_W-1:0] r_phase;
    logic               w_tick_end, w_div_end, w_last, w_run;
    logic               w_la, w_lb, w_ra, w_rb;

    assign w_tick_end = r_tick == TW'(TICK_CYCLES - 1);
    assign w_div_end  = r_div == DW'(PWM_DIV - 1);
    assign w_last     = (r_dur == 8'd0) || (w_tick_end && r_units == r_dur - 8'd1);
    // Counters and drive are live only while staying in RUN, so the exit cycle already coasts
    assign w_run      = (r_state == RUN) && (w_next == RUN);

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (executeStart ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? HOLD : RUN) :
                                     (executeStart ? HOLD : IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_l             <= '0;
            r_r             <= '0;
            r_dur           <= '0;
            r_units         <= '0;
            r_tick          <= '0;
            r_div           <= '0;
            r_phase         <= '0;
            executeComplete <= 1'b1;
            lmotorA         <= 1'b0;
            lmotorB         <= 1'b0;
            rmotorA         <= 1'b0;
            rmotorB         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && executeStart) begin
                r_l   <= lmotor;
                r_r   <= rmotor;
                r_dur <= dur;
            end
            r_tick          <= (w_run && !w_tick_end) ? r_tick + 1'b1 : '0;
            r_units         <= w_run ? r_units + 8'(w_tick_end) : '0;
            r_div           <= (w_run && !w_div_end) ? r_div + 1'b1 : '0;
            r_phase         <= w_run ? r_phase + SPEED_W'(w_div_end) : '0;
            executeComplete <= w_next != RUN;
            lmotorA         <= w_la;
            lmotorB         <= w_lb;
            rmotorA         <= w_ra;
            rmotorB         <= w_rb;
        end
    end

    pwm_gen u_left (
        .i_en    (w_run),
        .i_phase (r_phase),
        .i_speed (r_l[SPEED_W-1:0]),
        .i_dir   (r_l[DIR_BIT]),
        .o_a     (w_la),
        .o_b     (w_lb)
    );

    pwm_gen u_right (
        .i_en    (w_run),
        .i_phase (r_phase),
        .i_speed (r_r[SPEED_W-1:0]),
        .i_dir   (r_r[DIR_BIT]),
        .o_a     (w_ra),
        .o_b     (w_rb)
    );
endmodule

// File: tb/tb_motor_exec.sv
// tb_motor_exec: scoreboard bench for motor_exec with a run-level reference model
module tb_motor_exec;
    localparam int TICK = 256;

    logic       clk = 1'b0, reset_n = 1'b1, executeStart = 1'b0;
    logic [7:0] lmotor = '0, rmotor = '0, dur = '0;
    logic       executeComplete, lmotorA, lmotorB, rmotorA, rmotorB;
    int         compared = 0, mismatched = 0;

    typedef struct {int low; int la; int lb; int ra; int rb;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    motor_exec #(.PWM_DIV(1), .TICK_CYCLES(TICK)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .executeStart    (executeStart),
        .lmotor          (lmotor),
        .rmotor          (rmotor),
        .dur             (dur),
        .executeComplete (executeComplete),
        .lmotorA         (lmotorA),
        .lmotorB         (lmotorB),
        .rmotorA         (rmotorA),
        .rmotorB         (rmotorB)
    );

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // A run lasts dur*TICK cycles (one cycle for dur=0); each 128-step period gives speed active steps
    function automatic exp_t model(input logic [7:0] l, input logic [7:0] r, input logic [7:0] d);
        exp_t e;
        int periods;
        periods = int'(d) * TICK / 128;
        e.low = (d == 8'd0) ? 1 : int'(d) * TICK;
        e.la  = l[7]  ? periods * int'(l[6:0]) : 0;
        e.lb  = !l[7] ? periods * int'(l[6:0]) : 0;
        e.ra  = r[7]  ? periods * int'(r[6:0]) : 0;
        e.rb  = !r[7] ? periods * int'(r[6:0]) : 0;
        return e;
    endfunction

    bit running = 0;
    int low_c, la_c, lb_c, ra_c, rb_c;

    always @(negedge clk) begin
        exp_t e;
        if ((lmotorA && lmotorB) || (rmotorA && rmotorB)) begin
            mismatched++;
            $display("FAIL shoot_through: l=%b%b r=%b%b", lmotorA, lmotorB, rmotorA, rmotorB);
        end
        if (executeComplete && (lmotorA || lmotorB || rmotorA || rmotorB)) begin
            mismatched++;
            $display("FAIL coast: motors %b%b%b%b while complete", lmotorA, lmotorB, rmotorA, rmotorB);
        end
        if (!reset_n) running = 0;
        else if (!executeComplete) begin
            if (!running) begin
                running = 1;
                low_c = 0; la_c = 0; lb_c = 0; ra_c = 0; rb_c = 0;
            end
            low_c++;
            la_c += int'(lmotorA);
            lb_c += int'(lmotorB);
            ra_c += int'(rmotorA);
            rb_c += int'(rmotorB);
        end else if (running) begin
            running = 0;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_run: got run of %0d cycles, expected none", low_c);
            end else begin
                e = sb.pop_front();
                check("low_cycles", low_c, e.low);
                check("lmotorA_active", la_c, e.la);
                check("lmotorB_active", lb_c, e.lb);
                check("rmotorA_active", ra_c, e.ra);
                check("rmotorB_active", rb_c, e.rb);
            end
        end
    end

    task automatic wait_done();
        int t = 0;
        while (!executeComplete && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", int'(executeComplete), 1);
    endtask

    task automatic run_one(input logic [7:0] l, input logic [7:0] r, input logic [7:0] d, input bit hold);
        @(negedge clk);
        lmotor = l; rmotor = r; dur = d; executeStart = 1'b1;
        sb.push_back(model(l, r, d));
        @(negedge clk);
        check("start_ack", int'(executeComplete), 0);
        if (!hold) executeStart = 1'b0;
        lmotor = 8'($urandom); rmotor = 8'($urandom); dur = 8'($urandom);
        wait_done();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int fell;
        #2 reset_n = 1'b0;
        #3;
        check("reset_complete", int'(executeComplete), 1);
        check("reset_motors", int'({lmotorA, lmotorB, rmotorA, rmotorB}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_complete", int'(executeComplete), 1);

        run_one(8'h95, 8'hB6, 8'd3, 1'b0);
        run_one(8'h7F, 8'h00, 8'd1, 1'b0);
        run_one(8'h35, 8'h00, 8'd0, 1'b0);

        run_one(8'h81, 8'hFF, 8'd1, 1'b1);
        fell = 0;
        repeat (300) begin
            @(negedge clk);
            if (!executeComplete) fell++;
        end
        check("hold_no_rerun", fell, 0);
        executeStart = 1'b0;
        repeat (2) @(negedge clk);
        run_one(8'h10, 8'h90, 8'd1, 1'b0);

        @(negedge clk);
        lmotor = 8'hFF; rmotor = 8'h05; dur = 8'd2; executeStart = 1'b1;
        @(negedge clk);
        executeStart = 1'b0;
        lmotor = 8'h00;
        repeat (98) @(negedge clk);
        check("pre_reset_active", int'(lmotorA), 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrun_reset_complete", int'(executeComplete), 1);
        check("midrun_reset_motors", int'({lmotorA, lmotorB, rmotorA, rmotorB}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", int'(executeComplete), 1);

        @(negedge clk);
        reset_n = 1'b0;
        lmotor = 8'h40; rmotor = 8'hC0; dur = 8'd1; executeStart = 1'b1;
        sb.push_back(model(8'h40, 8'hC0, 8'd1));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("start_after_reset", int'(executeComplete), 0);
        executeStart = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        for (int i = 0; i < 25; i++)
            run_one(8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)), 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
